// File: rtl/add_pkg.sv
// Shared types and constants for the add_* nibble-serial sequencers.
package add_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} add_seq_st_e;
    localparam int NIB_W = 4;
endpackage

// File: rtl/add_04bit_ahead.sv
// 4-bit carry-lookahead adder, purely combinational.
module add_04bit_ahead (
    input  logic [3:0] i_num_a,
    input  logic [3:0] i_num_b,
    input  logic       i_cry,
    output logic [3:0] o_res,
    output logic       o_cry
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = i_num_a & i_num_b;
    assign p = i_num_a ^ i_num_b;

    // Every carry is flattened from g/p and the carry-in, so no ripple chain.
    assign c[0] = i_cry;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign o_res = p ^ c[3:0];
    assign o_cry = c[4];
endmodule

// File: rtl/add_serial_ctrl.sv
// Nibble-serial add/subtract through one shared 4-bit CLA; LSB nibble first.
// Result valid DATA_W/4+1 cycles after accept; held in DONE until the consumer takes it.
module add_serial_ctrl
    import add_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_vld,
    output logic              o_rdy,
    input  logic [DATA_W-1:0] i_num_a,
    input  logic [DATA_W-1:0] i_num_b,
    input  logic              i_cry,
    input  logic              i_sub,
    output logic              o_vld,
    input  logic              i_rdy,
    output logic [DATA_W-1:0] o_res,
    output logic              o_cry,
    output logic              o_ovf
);
    localparam int NIB_N = DATA_W / NIB_W;
    localparam int CNT_W = (NIB_N > 1) ? $clog2(NIB_N) : 1;

    if ((DATA_W % NIB_W) != 0 || DATA_W < 8) begin : g_bad_width
        $error("add_serial_ctrl: DATA_W must be a multiple of 4 and at least 8");
    end

    add_seq_st_e       state;
    logic [DATA_W-1:0] a_sh;
    logic [DATA_W-1:0] b_sh;
    logic [DATA_W-1:0] res_sh;
    logic              cry_q;
    logic              msb_a;
    logic              msb_b;
    logic [CNT_W-1:0]  cnt;

    logic [NIB_W-1:0]  add_res;
    logic              add_cry;
    logic [DATA_W-1:0] res_next;

    add_04bit_ahead u_add_04bit_ahead (
        .i_num_a (a_sh[NIB_W-1:0]),
        .i_num_b (b_sh[NIB_W-1:0]),
        .i_cry   (cry_q),
        .o_res   (add_res),
        .o_cry   (add_cry)
    );

    assign res_next = {add_res, res_sh[DATA_W-1:NIB_W]};
    assign o_rdy    = (state == ST_IDLE);
    assign o_vld    = (state == ST_DONE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            cry_q  <= 1'b0;
            msb_a  <= 1'b0;
            msb_b  <= 1'b0;
            cnt    <= '0;
            o_res  <= '0;
            o_cry  <= 1'b0;
            o_ovf  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_vld) begin
                        // Subtract is folded into an add of ~B with a forced carry-in.
                        a_sh  <= i_num_a;
                        b_sh  <= i_sub ? ~i_num_b : i_num_b;
                        cry_q <= i_sub | i_cry;
                        msb_a <= i_num_a[DATA_W-1];
                        msb_b <= i_sub ? ~i_num_b[DATA_W-1] : i_num_b[DATA_W-1];
                        cnt   <= '0;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    a_sh   <= a_sh >> NIB_W;
                    b_sh   <= b_sh >> NIB_W;
                    res_sh <= res_next;
                    cry_q  <= add_cry;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NIB_N - 1)) begin
                        o_res <= res_next;
                        o_cry <= add_cry;
                        o_ovf <= (msb_a == msb_b) && (add_res[NIB_W-1] != msb_a);
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_rdy) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_add_serial_ctrl.sv
// Randomized and directed bench for add_serial_ctrl (DATA_W=32) against an arithmetic model.
module tb_add_serial_ctrl;
    localparam int DW  = 32;
    localparam int LAT = 9;

    logic          clk;
    logic          rst;
    logic          vld;
    logic          rdy_o;
    logic [DW-1:0] num_a;
    logic [DW-1:0] num_b;
    logic          cin;
    logic          sub;
    logic          vld_o;
    logic          rdy;
    logic [DW-1:0] res;
    logic          cry;
    logic          ovf;

    int checks = 0;
    int errors = 0;

    add_serial_ctrl #(.DATA_W(DW)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_vld   (vld),
        .o_rdy   (rdy_o),
        .i_num_a (num_a),
        .i_num_b (num_b),
        .i_cry   (cin),
        .i_sub   (sub),
        .o_vld   (vld_o),
        .i_rdy   (rdy),
        .o_res   (res),
        .o_cry   (cry),
        .o_ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: {ovf, carry, result} from two's-complement arithmetic on wide integers.
    function automatic logic [DW+1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic c, input logic s);
        logic [DW:0] u;
        longint      sv;
        logic        o;
        if (s) begin
            u  = {(a >= b), a - b};
            sv = longint'($signed(a)) - longint'($signed(b));
        end else begin
            u  = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, c};
            sv = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
        end
        o = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
        return {o, u};
    endfunction

    task automatic wait_rdy(input string tag);
        int n;
        n = 0;
        while (!rdy_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_o) chk({tag, "_rdy_timeout"}, 0, 1);
    endtask

    // One operation: handshake, latency check, result check, optional DONE hold, accept.
    task automatic do_op(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic c, input logic s, input logic [DW-1:0] er,
                         input logic ec, input logic eo, input int hold);
        int n;
        wait_rdy(tag);
        num_a = a; num_b = b; cin = c; sub = s; vld = 1'b1;
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                vld = 1'b0;
                num_a = $urandom; num_b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            end
            chk({tag, "_busy_rdy"}, rdy_o, 0);
        end while (!vld_o && n < 20);
        chk({tag, "_latency"}, n, LAT);
        chk({tag, "_res"}, res, er);
        chk({tag, "_cry"}, cry, ec);
        chk({tag, "_ovf"}, ovf, eo);
        for (int i = 0; i < hold; i++) begin
            vld = 1'b1; num_a = $urandom; num_b = $urandom;
            @(negedge clk);
            chk({tag, "_hold_vld"}, vld_o, 1);
            chk({tag, "_hold_rdy"}, rdy_o, 0);
            chk({tag, "_hold_res"}, {eo, ec, res}, {eo, ec, er});
            chk({tag, "_hold_flags"}, {ovf, cry}, {eo, ec});
        end
        vld = 1'b0;
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        chk({tag, "_idle_rdy"}, rdy_o, 1);
        chk({tag, "_idle_vld"}, vld_o, 0);
        chk({tag, "_idle_keep"}, {ovf, cry, res}, {eo, ec, er});
    endtask

    initial begin
        logic [DW+1:0]  m;
        logic [DW+1:0]  exp_q[$];
        logic [DW+1:0]  e;
        int             n_acc;
        int             last_acc;
        int             cyc;

        rst = 1'b1; vld = 1'b0; rdy = 1'b0;
        num_a = '0; num_b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rdy", rdy_o, 1);
        chk("reset_vld", vld_o, 0);
        chk("reset_outs", {ovf, cry, res}, 0);

        do_op("add_wrap", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 0);
        do_op("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0);
        do_op("add_cin",  32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0, 32'h2143_6588, 1'b0, 1'b0, 0);
        do_op("sub_neg",  32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 0);
        do_op("sub_ovf",  32'h8000_0000, 32'd1, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 0);
        do_op("bp",       32'hA5A5_0003, 32'h0101_0101, 1'b0, 1'b0, 32'hA6A6_0104, 1'b0, 1'b0, 5);

        // Reset in the middle of CALC discards the operation.
        wait_rdy("rst");
        num_a = 32'hFFFF_0000; num_b = 32'h0001_0000; cin = 1'b0; sub = 1'b0; vld = 1'b1;
        @(posedge clk);
        repeat (3) @(negedge clk);
        vld = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_vld", vld_o, 0);
        chk("rst_mid_rdy", rdy_o, 1);
        chk("rst_mid_outs", {ovf, cry, res}, 0);
        do_op("after_rst", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0, 0);

        // Streaming with both handshakes held high.
        rdy = 1'b1;
        n_acc = 0;
        last_acc = -1;
        for (cyc = 0; cyc < 200 && (n_acc < 4 || exp_q.size() > 0); cyc++) begin
            @(negedge clk);
            if (vld_o) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("stream_res", res, e[DW-1:0]);
                    chk("stream_cry", cry, e[DW]);
                    chk("stream_ovf", ovf, e[DW+1]);
                end else begin
                    chk("stream_spurious_vld", vld_o, 0);
                end
            end
            if (rdy_o && n_acc < 4) begin
                num_a = $urandom; num_b = $urandom;
                cin = 1'($urandom); sub = 1'($urandom);
                vld = 1'b1;
                m = model(num_a, num_b, cin, sub);
                exp_q.push_back(m);
                if (last_acc >= 0) chk("stream_interval", cyc - last_acc, 10);
                last_acc = cyc;
                n_acc++;
            end else if (rdy_o) begin
                vld = 1'b0;
            end else begin
                num_a = $urandom; num_b = $urandom;
                cin = 1'($urandom); sub = 1'($urandom);
            end
        end
        vld = 1'b0;
        rdy = 1'b0;
        chk("stream_accepts", n_acc, 4);
        chk("stream_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
